// File: rtl/snoop_bus_arbiter.sv
// Round-robin owner selection for the shared snoop bus: one tenure at a time,
// registered one-hot grant, encoded owner ID and a hold-length diagnostic.
module snoop_bus_arbiter #(
    parameter int NUM_CPUS = 4,
    parameter int MAX_HOLD = 16,
    parameter int IDW      = $clog2(NUM_CPUS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_CPUS-1:0] req,
    input  logic [NUM_CPUS-1:0] busy,
    output logic [NUM_CPUS-1:0] gnt,
    output logic                gnt_valid,
    output logic [IDW-1:0]      gnt_id,
    output logic                hold_timeout,
    output logic                timeout_seen
);

    localparam int CNTW = $clog2(MAX_HOLD + 1);
    localparam logic [CNTW-1:0] HOLD_MAX = CNTW'(MAX_HOLD);
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_OWNED = 1'b1;

    logic [0:0]          state_reg,        state_next;
    logic [NUM_CPUS-1:0] gnt_reg,          gnt_next;
    logic                gnt_valid_reg,    gnt_valid_next;
    logic [IDW-1:0]      gnt_id_reg,       gnt_id_next;
    logic [IDW-1:0]      rr_ptr_reg,       rr_ptr_next;
    logic [CNTW-1:0]     hold_cnt_reg,     hold_cnt_next;
    logic                hold_hit_reg,     hold_hit_next;
    logic                hold_timeout_reg, hold_timeout_next;
    logic                timeout_seen_reg, timeout_seen_next;

    // Requests viewed in priority order: slot gi holds cache (rr_ptr + gi) mod NUM_CPUS.
    logic [IDW:0]        rot_sum [NUM_CPUS];
    logic [IDW:0]        rot_idx [NUM_CPUS];
    logic [NUM_CPUS-1:0] rot_req;

    generate
        for (genvar gi = 0; gi < NUM_CPUS; gi++) begin : g_rot
            assign rot_sum[gi] = {1'b0, rr_ptr_reg} + (IDW+1)'(gi);
            assign rot_idx[gi] = (rot_sum[gi] >= (IDW+1)'(NUM_CPUS))
                               ? rot_sum[gi] - (IDW+1)'(NUM_CPUS)
                               : rot_sum[gi];
            assign rot_req[gi] = req[rot_idx[gi][IDW-1:0]];
        end
    endgenerate

    logic [IDW:0]        win_idx;
    logic [IDW-1:0]      win_id;
    logic [NUM_CPUS-1:0] win_onehot;
    logic                owner_keep;

    always_comb begin
        win_idx = '0;
        for (int k = NUM_CPUS - 1; k >= 0; k--) begin
            if (rot_req[k]) begin
                win_idx = rot_idx[k];
            end
        end
    end

    assign win_id     = win_idx[IDW-1:0];
    assign win_onehot = NUM_CPUS'(1) << win_id;
    assign owner_keep = req[gnt_id_reg] | busy[gnt_id_reg];

    always_comb begin
        state_next        = state_reg;
        gnt_next          = gnt_reg;
        gnt_valid_next    = gnt_valid_reg;
        gnt_id_next       = gnt_id_reg;
        rr_ptr_next       = rr_ptr_reg;
        hold_cnt_next     = hold_cnt_reg;
        hold_hit_next     = 1'b0;
        hold_timeout_next = 1'b0;
        timeout_seen_next = timeout_seen_reg;

        case (state_reg)
            ST_IDLE: begin
                if (|req) begin
                    state_next     = ST_OWNED;
                    gnt_next       = win_onehot;
                    gnt_valid_next = 1'b1;
                    gnt_id_next    = win_id;
                    hold_cnt_next  = CNT_ONE;
                    hold_hit_next  = (CNT_ONE == HOLD_MAX);
                end
            end
            ST_OWNED: begin
                if (owner_keep) begin
                    if (hold_cnt_reg != HOLD_MAX) begin
                        hold_cnt_next = hold_cnt_reg + CNT_ONE;
                        hold_hit_next = ((hold_cnt_reg + CNT_ONE) == HOLD_MAX);
                    end
                    // The pulse lands one cycle after the counter saturates.
                    if (hold_hit_reg) begin
                        hold_timeout_next = 1'b1;
                        timeout_seen_next = 1'b1;
                    end
                end else begin
                    state_next     = ST_IDLE;
                    gnt_next       = '0;
                    gnt_valid_next = 1'b0;
                    hold_cnt_next  = '0;
                    rr_ptr_next    = (gnt_id_reg == IDW'(NUM_CPUS - 1))
                                   ? '0 : gnt_id_reg + IDW'(1);
                end
            end
            default: begin
                state_next     = ST_IDLE;
                gnt_next       = '0;
                gnt_valid_next = 1'b0;
                hold_cnt_next  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg        <= ST_IDLE;
            gnt_reg          <= '0;
            gnt_valid_reg    <= 1'b0;
            gnt_id_reg       <= '0;
            rr_ptr_reg       <= '0;
            hold_cnt_reg     <= '0;
            hold_hit_reg     <= 1'b0;
            hold_timeout_reg <= 1'b0;
            timeout_seen_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            gnt_reg          <= gnt_next;
            gnt_valid_reg    <= gnt_valid_next;
            gnt_id_reg       <= gnt_id_next;
            rr_ptr_reg       <= rr_ptr_next;
            hold_cnt_reg     <= hold_cnt_next;
            hold_hit_reg     <= hold_hit_next;
            hold_timeout_reg <= hold_timeout_next;
            timeout_seen_reg <= timeout_seen_next;
        end
    end

    assign gnt          = gnt_reg;
    assign gnt_valid    = gnt_valid_reg;
    assign gnt_id       = gnt_id_reg;
    assign hold_timeout = hold_timeout_reg;
    assign timeout_seen = timeout_seen_reg;

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Directed bench: stimulus pushes expected tenures, a monitor pops one per
// observed tenure and compares owner, length, gap and timeout position.
module tb_snoop_bus_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] busy;
    logic [3:0] gnt;
    logic       gnt_valid;
    logic [1:0] gnt_id;
    logic       hold_timeout;
    logic       timeout_seen;

    int errors = 0;
    int checks = 0;

    snoop_bus_arbiter #(
        .NUM_CPUS (4),
        .MAX_HOLD (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .busy         (busy),
        .gnt          (gnt),
        .gnt_valid    (gnt_valid),
        .gnt_id       (gnt_id),
        .hold_timeout (hold_timeout),
        .timeout_seen (timeout_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] gnt;
        int         id;
        int         len;
        int         gap;
        int         to_cyc;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [3:0] g, input int id, input int len, input int gap, input int to_cyc);
        exp_t e;
        e.gnt = g; e.id = id; e.len = len; e.gap = gap; e.to_cyc = to_cyc;
        exp_q.push_back(e);
    endtask

    // Drive at the current falling edge and hold for n sampling edges.
    task automatic drive(input logic [3:0] r, input logic [3:0] b, input int n);
        req  = r;
        busy = b;
        repeat (n) @(negedge clk);
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    logic       in_ten = 1'b0;
    logic [3:0] cur_gnt;
    int         cur_id, cur_len, cur_gap, to_cyc, to_cnt;
    int         idle_cnt = 0;
    int         total_pulses = 0;

    always @(posedge clk) begin
        #1;
        chk("inv_onehot", 32'($onehot0(gnt)), 32'd1);
        chk("inv_valid", 32'(gnt_valid), 32'(|gnt));
        if (gnt_valid) chk("inv_owner", 32'(gnt[gnt_id]), 32'd1);
        if (hold_timeout) total_pulses++;
        if (gnt_valid) begin
            if (!in_ten) begin
                in_ten  = 1'b1;
                cur_gnt = gnt;
                cur_id  = int'(gnt_id);
                cur_len = 1;
                cur_gap = idle_cnt;
                to_cyc  = 0;
                to_cnt  = 0;
            end else begin
                cur_len++;
                chk("gnt_stable", 32'(gnt), 32'(cur_gnt));
            end
            if (hold_timeout) begin
                to_cnt++;
                to_cyc = cur_len;
            end
        end else begin
            if (in_ten) begin
                in_ten = 1'b0;
                if (exp_q.size() == 0) begin
                    chk("unexpected_tenure", 32'(cur_gnt), 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("ten_gnt", 32'(cur_gnt), 32'(e.gnt));
                    chk("ten_id", 32'(cur_id), 32'(e.id));
                    chk("ten_len", 32'(cur_len), 32'(e.len));
                    if (e.gap >= 0) chk("ten_gap", 32'(cur_gap), 32'(e.gap));
                    chk("ten_timeout_cycle", 32'(to_cyc), 32'(e.to_cyc));
                    chk("ten_timeout_count", 32'(to_cnt), (e.to_cyc != 0) ? 32'd1 : 32'd0);
                    $display("tenure gnt=%b id=%0d len=%0d gap=%0d timeout_at=%0d",
                             cur_gnt, cur_id, cur_len, cur_gap, to_cyc);
                end
                idle_cnt = 0;
            end
            idle_cnt++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    logic [3:0] one;
    int         nxt;

    initial begin
        one  = 4'b0001;
        rst  = 1'b1;
        req  = 4'b0000;
        busy = 4'b0000;
        #1 rst = 1'b0;
        req = 4'b1111;

        // Reset values with all requests asserted
        repeat (3) @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_gnt_valid", 32'(gnt_valid), 32'd0);
        chk("rst_gnt_id", 32'(gnt_id), 32'd0);
        chk("rst_hold_timeout", 32'(hold_timeout), 32'd0);
        chk("rst_timeout_seen", 32'(timeout_seen), 32'd0);

        push(4'b0001, 0, 1, -1, 0);
        rst = 1'b1;
        drive(4'b1111, 4'b0000, 1);
        chk("first_gnt", 32'(gnt), 32'b0001);
        chk("first_gnt_id", 32'(gnt_id), 32'd0);

        // Round-robin: owner drops its bit for one cycle, everyone else keeps requesting
        for (int i = 0; i < 4; i++) begin
            nxt = (i + 1) % 4;
            push(one << nxt, nxt, 1, 1, 0);
            drive(4'b1111 & ~(one << i), 4'b0000, 1);
            chk("rr_dead", 32'(gnt), 32'd0);
            drive(4'b1111, 4'b0000, 1);
            chk("rr_gnt", 32'(gnt), 32'(one << nxt));
        end

        // Wrap-around skip: after CPU2 releases rr_ptr=3, 0101 must pick CPU0
        push(4'b0100, 2, 1, 1, 0);
        drive(4'b0100, 4'b0000, 2);
        chk("wrap_pre_gnt", 32'(gnt), 32'b0100);
        push(4'b0001, 0, 1, 1, 0);
        drive(4'b0000, 4'b0000, 1);
        drive(4'b0101, 4'b0000, 1);
        chk("wrap_gnt", 32'(gnt), 32'b0001);
        chk("wrap_gnt_id", 32'(gnt_id), 32'd0);

        // Busy extension with a competing request from CPU2
        push(4'b0010, 1, 6, 1, 0);
        drive(4'b0010, 4'b0000, 2);
        chk("busy_gnt", 32'(gnt), 32'b0010);
        drive(4'b0100, 4'b0010, 5);
        chk("busy_hold", 32'(gnt), 32'b0010);
        push(4'b0100, 2, 1, 1, 0);
        drive(4'b0100, 4'b0000, 1);
        chk("busy_dead", 32'(gnt), 32'd0);
        drive(4'b0100, 4'b0000, 1);
        chk("busy_next_gnt", 32'(gnt), 32'b0100);

        // Timeout: CPU3 holds busy for 30 cycles
        push(4'b1000, 3, 31, 1, 17);
        drive(4'b1000, 4'b0000, 2);
        chk("to_gnt", 32'(gnt), 32'b1000);
        chk("to_seen_before", 32'(timeout_seen), 32'd0);
        drive(4'b0000, 4'b1000, 30);
        chk("to_seen_after", 32'(timeout_seen), 32'd1);
        chk("to_gnt_persist", 32'(gnt), 32'b1000);
        chk("to_pulse_done", 32'(hold_timeout), 32'd0);
        drive(4'b0000, 4'b0000, 1);
        chk("to_release", 32'(gnt), 32'd0);
        chk("to_seen_sticky", 32'(timeout_seen), 32'd1);

        // Asynchronous reset in the middle of a CPU2 tenure
        push(4'b0100, 2, 4, 1, 0);
        drive(4'b0100, 4'b0000, 1);
        chk("mid_gnt", 32'(gnt), 32'b0100);
        drive(4'b0100, 4'b0000, 3);
        #3 rst = 1'b0;
        #1;
        chk("mid_rst_gnt", 32'(gnt), 32'd0);
        chk("mid_rst_gnt_valid", 32'(gnt_valid), 32'd0);
        chk("mid_rst_gnt_id", 32'(gnt_id), 32'd0);
        chk("mid_rst_timeout_seen", 32'(timeout_seen), 32'd0);
        @(negedge clk);
        push(4'b0100, 2, 1, 1, 0);
        rst = 1'b1;
        drive(4'b0100, 4'b0000, 1);
        chk("regrant_gnt", 32'(gnt), 32'b0100);
        chk("regrant_gnt_id", 32'(gnt_id), 32'd2);
        drive(4'b0000, 4'b0000, 1);
        drive(4'b0000, 4'b0000, 3);

        chk("end_gnt_valid", 32'(gnt_valid), 32'd0);
        chk("end_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("end_total_pulses", 32'(total_pulses), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
